// File: rtl/cordic_sequencer_if.sv
// Handshake and datapath-control bundle between a CORDIC sequencer and its
// requester/datapath.
interface cordic_sequencer_if;
  logic       START;
  logic       MODE;
  logic       ABORT;
  logic       ACK;
  logic       Z_SIGN;
  logic       Y_SIGN;
  logic       LOAD;
  logic       ITER_EN;
  logic [5:0] ITER_IDX;
  logic       DIR;
  logic       MODE_Q;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, MODE, ABORT, ACK, Z_SIGN, Y_SIGN,
    input  LOAD, ITER_EN, ITER_IDX, DIR, MODE_Q, BUSY, DONE
  );

  modport slave (
    input  START, MODE, ABORT, ACK, Z_SIGN, Y_SIGN,
    output LOAD, ITER_EN, ITER_IDX, DIR, MODE_Q, BUSY, DONE
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Moore control FSM for an iterative CORDIC datapath: one load cycle, ITERS
// micro-rotation cycles, then a result held until acknowledged.
module cordic_sequencer #(
  parameter int ITERS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  cordic_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(ITERS - 1);

  state_t     r_state;
  logic [5:0] r_idx;
  logic       r_modeQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_modeQ <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (bus.START) begin
            r_state <= S_LOAD;
            r_modeQ <= bus.MODE;
          end
        end
        S_LOAD: begin
          r_idx   <= '0;
          r_state <= bus.ABORT ? S_IDLE : S_ITER;
        end
        S_ITER: begin
          // Counter returns to zero on every exit so it never wraps mid-operation.
          if (bus.ABORT) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_DONE: begin
          r_idx <= '0;
          if (bus.ABORT || bus.ACK) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  logic w_inIter;
  assign w_inIter = (r_state == S_ITER);

  assign bus.LOAD     = (r_state == S_LOAD);
  assign bus.ITER_EN  = w_inIter;
  assign bus.BUSY     = (r_state == S_LOAD) || w_inIter;
  assign bus.DONE     = (r_state == S_DONE);
  assign bus.ITER_IDX = w_inIter ? r_idx : 6'd0;
  assign bus.MODE_Q   = r_modeQ;
  // Rotation drives the angle toward zero; vectoring drives Y toward zero.
  assign bus.DIR      = w_inIter && (r_modeQ ? bus.Y_SIGN : ~bus.Z_SIGN);

endmodule

// File: tb/tb_cordic_sequencer.sv
// Scoreboard bench for cordic_sequencer: stimulus queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_cordic_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, abort, ack, zs, ys;

  cordic_sequencer_if bus16 ();
  cordic_sequencer_if bus1 ();

  assign bus16.START  = start;
  assign bus16.MODE   = mode;
  assign bus16.ABORT  = abort;
  assign bus16.ACK    = ack;
  assign bus16.Z_SIGN = zs;
  assign bus16.Y_SIGN = ys;
  assign bus1.START   = start;
  assign bus1.MODE    = mode;
  assign bus1.ABORT   = abort;
  assign bus1.ACK     = ack;
  assign bus1.Z_SIGN  = zs;
  assign bus1.Y_SIGN  = ys;

  cordic_sequencer #(.ITERS(16)) dut16 (.CLK(clk), .RST(rst), .bus(bus16));
  cordic_sequencer #(.ITERS(1))  dut1  (.CLK(clk), .RST(rst), .bus(bus1));

  typedef struct packed {
    logic       load;
    logic       iterEn;
    logic [5:0] idx;
    logic       dir;
    logic       modeQ;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t  q16[$];
  obs_t  q1[$];
  string n16[$];
  string n1[$];
  int    sel;
  int    checks = 0;
  int    fails  = 0;

  function automatic obs_t eIdle(logic mq);
    obs_t e = '0;
    e.modeQ = mq;
    return e;
  endfunction

  function automatic obs_t eLoad(logic mq);
    obs_t e = '0;
    e.load  = 1'b1;
    e.busy  = 1'b1;
    e.modeQ = mq;
    return e;
  endfunction

  function automatic obs_t eIter(int i, logic d, logic mq);
    obs_t e = '0;
    e.iterEn = 1'b1;
    e.busy   = 1'b1;
    e.idx    = 6'(i);
    e.dir    = d;
    e.modeQ  = mq;
    return e;
  endfunction

  function automatic obs_t eDone(logic mq);
    obs_t e = '0;
    e.done  = 1'b1;
    e.modeQ = mq;
    return e;
  endfunction

  task automatic checkOutput(string tag, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got load=%0b iterEn=%0b idx=%0d dir=%0b modeQ=%0b busy=%0b done=%0b, expected load=%0b iterEn=%0b idx=%0d dir=%0b modeQ=%0b busy=%0b done=%0b",
               tag, act.load, act.iterEn, act.idx, act.dir, act.modeQ, act.busy, act.done,
               exp.load, exp.iterEn, exp.idx, exp.dir, exp.modeQ, exp.busy, exp.done);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and queue what the
  // outputs must show during that cycle.
  task automatic applyStimulus(string tag, logic st, logic md, logic ab, logic ak,
                               logic z, logic y, logic r, obs_t e);
    @(posedge clk);
    #1;
    start = st; mode = md; abort = ab; ack = ak; zs = z; ys = y; rst = r;
    if (sel == 0) begin
      q16.push_back(e);
      n16.push_back(tag);
    end else if (sel == 1) begin
      q1.push_back(e);
      n1.push_back(tag);
    end
  endtask

  always @(negedge clk) begin
    obs_t act;
    if (q16.size() > 0) begin
      act = {bus16.LOAD, bus16.ITER_EN, bus16.ITER_IDX, bus16.DIR,
             bus16.MODE_Q, bus16.BUSY, bus16.DONE};
      checkOutput(n16.pop_front(), act, q16.pop_front());
    end
    if (q1.size() > 0) begin
      act = {bus1.LOAD, bus1.ITER_EN, bus1.ITER_IDX, bus1.DIR,
             bus1.MODE_Q, bus1.BUSY, bus1.DONE};
      checkOutput(n1.pop_front(), act, q1.pop_front());
    end
  end

  initial begin
    logic b;
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; ack = 1'b0;
    zs = 1'b0; ys = 1'b0; sel = 0;
    repeat (3) @(posedge clk);

    // Basic rotation run with ignored START/ACK pulses along the way
    applyStimulus("reset",     0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("idleAbort", 0, 0, 1, 0, 0, 0, 0, eIdle(0));
    applyStimulus("idleAck",   0, 0, 0, 1, 0, 0, 0, eIdle(0));
    applyStimulus("accept",    1, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("load",      0, 0, 0, 0, 0, 0, 0, eLoad(0));
    for (int i = 0; i < 16; i++)
      applyStimulus("iter", i == 3, 0, 0, i == 5, 0, 0, 0, eIter(i, 1'b1, 0));
    for (int k = 0; k < 3; k++)
      applyStimulus("doneHold", k == 1, 0, 0, 0, 0, 0, 0, eDone(0));
    applyStimulus("doneAck",   0, 0, 0, 1, 0, 0, 0, eDone(0));
    applyStimulus("idleAfterAck", 0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("idleStay",  0, 0, 0, 0, 0, 0, 0, eIdle(0));

    // Vectoring: DIR follows Y_SIGN, Z_SIGN irrelevant
    applyStimulus("acceptV",   1, 1, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("loadV",     0, 0, 0, 0, 0, 1, 0, eLoad(1));
    for (int i = 0; i < 16; i++) begin
      b = 1'(i % 2);
      applyStimulus("iterV", 0, 0, 0, 0, ~b, b, 0, eIter(i, b, 1));
    end
    applyStimulus("doneV",     0, 0, 0, 0, 0, 1, 0, eDone(1));
    applyStimulus("ackV",      0, 0, 0, 1, 0, 1, 0, eDone(1));
    applyStimulus("idleV",     0, 0, 0, 0, 0, 0, 0, eIdle(1));

    // Rotation with negative angle: DIR=0; MODE input wiggles, MODE_Q holds
    applyStimulus("acceptR",   1, 0, 0, 0, 0, 0, 0, eIdle(1));
    applyStimulus("loadR",     0, 1, 0, 0, 1, 1, 0, eLoad(0));
    for (int i = 0; i < 16; i++)
      applyStimulus("iterR", 0, 1, 0, 0, 1, 1, 0, eIter(i, 1'b0, 0));
    applyStimulus("doneR",     0, 1, 0, 0, 0, 0, 0, eDone(0));
    applyStimulus("ackStart",  1, 1, 0, 1, 0, 0, 0, eDone(0));
    applyStimulus("noLoad",    0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("noLoad2",   0, 0, 0, 0, 0, 0, 0, eIdle(0));

    // Abort at index 7, then ABORT+START in IDLE starts a full run
    applyStimulus("acceptA",   1, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("loadA",     0, 0, 0, 0, 0, 0, 0, eLoad(0));
    for (int i = 0; i < 8; i++)
      applyStimulus("iterA", 0, 0, i == 7, 0, 0, 0, 0, eIter(i, 1'b1, 0));
    applyStimulus("abortIdle", 0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("abortNoDone", 0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("abortStart", 1, 1, 1, 0, 0, 0, 0, eIdle(0));
    applyStimulus("loadB",     0, 0, 0, 0, 0, 0, 0, eLoad(1));
    for (int i = 0; i < 16; i++)
      applyStimulus("iterB", 0, 0, 0, 0, 0, 0, 0, eIter(i, 1'b0, 1));
    applyStimulus("doneB",     0, 0, 0, 0, 0, 0, 0, eDone(1));
    applyStimulus("doneAbort", 0, 0, 1, 0, 0, 0, 0, eDone(1));
    applyStimulus("idleB",     0, 0, 0, 0, 0, 0, 0, eIdle(1));

    // Reset mid-ITER, reset in DONE, reset together with START
    applyStimulus("acceptC",   1, 1, 0, 0, 0, 0, 0, eIdle(1));
    applyStimulus("loadC",     0, 0, 0, 0, 0, 1, 0, eLoad(1));
    for (int i = 0; i < 4; i++)
      applyStimulus("iterC", 0, 0, 0, 0, 0, 1, i == 3, eIter(i, 1'b1, 1));
    applyStimulus("rstIter",   0, 0, 0, 0, 0, 1, 0, eIdle(0));
    applyStimulus("acceptD",   1, 1, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("loadD",     0, 0, 0, 0, 0, 1, 0, eLoad(1));
    for (int i = 0; i < 16; i++)
      applyStimulus("iterD", 0, 0, 0, 0, 0, 1, 0, eIter(i, 1'b1, 1));
    applyStimulus("doneD",     0, 0, 0, 0, 0, 1, 1, eDone(1));
    applyStimulus("rstDone",   0, 0, 0, 0, 0, 1, 0, eIdle(0));
    applyStimulus("rstStart",  1, 1, 0, 0, 0, 0, 1, eIdle(0));
    applyStimulus("stillIdle", 0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("stillIdle2", 0, 0, 0, 0, 0, 0, 0, eIdle(0));

    // Single-iteration instance
    sel = 2;
    applyStimulus("rst1",      0, 0, 0, 0, 0, 0, 1, eIdle(0));
    sel = 1;
    applyStimulus("reset1",    0, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("accept1",   1, 0, 0, 0, 0, 0, 0, eIdle(0));
    applyStimulus("load1",     0, 0, 0, 0, 0, 0, 0, eLoad(0));
    applyStimulus("iter1",     0, 0, 0, 0, 0, 0, 0, eIter(0, 1'b1, 0));
    applyStimulus("done1",     0, 0, 0, 0, 0, 0, 0, eDone(0));
    applyStimulus("done1Ack",  0, 0, 0, 1, 0, 0, 0, eDone(0));
    applyStimulus("idle1",     0, 0, 0, 0, 0, 0, 0, eIdle(0));

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q16.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d/%0d pending entries, expected 0/0",
               q16.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
